decoder_arm_ldm_seq: RTL and testbench

Sequential expander for ARM block-transfer instructions (LDM/STM).
- Accepts one decoded block-transfer word plus the base register value from the decode stage.
- Issues one single-register memory micro-op per set bit of the register list, in ascending register order, toward the AHB load/store path.
- Produces the base-register writeback at the end of the sequence.
- Generalises the single-cycle decode path to a multi-cycle, width-parametrised sequencer with a valid/ready handshake on both sides.

---
 rtl/decoder_arm_ldm_seq.sv | 159 +++++++++++++++
 tb/tb_decoder_arm_ldm_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_arm_ldm_seq.sv
// Expands one ARM LDM/STM instruction into per-register memory micro-ops, lowest register first.
// Optional: define DECODER_LDM_PC_BRANCH_EN to flag the micro-op that loads the PC.
module decoder_arm_ldm_seq #(
   parameter int NUM_REGS = 16,
   parameter int ADDR_W   = 32,
   parameter int STRIDE   = 4,
   localparam int RID_W   = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       code,
   input  logic [ADDR_W-1:0] base,
   output logic              uop_valid,
   input  logic              uop_ready,
   output logic [ADDR_W-1:0] uop_addr,
   output logic [RID_W-1:0]  uop_reg,
   output logic              uop_load,
   output logic              uop_last,
   output logic              uop_pc_load,
   output logic              wb_en,
   output logic [ADDR_W-1:0] wb_value,
   output logic              empty_list
);

   // Both handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; the producer holds its outputs stable until that edge.
   typedef enum logic {IDLE, ISSUE} state_t;

   state_t              state;
   logic [NUM_REGS-1:0] rem;
   logic                wb_q;
   logic [ADDR_W-1:0]   wb_target;

   logic [NUM_REGS-1:0] list_in;
   logic [NUM_REGS-1:0] rem_after;
   logic [NUM_REGS-1:0] sel;
   logic [RID_W-1:0]    sel_reg;
   logic                sel_single;
   logic [ADDR_W-1:0]   count;
   logic [ADDR_W-1:0]   span;
   logic [ADDR_W-1:0]   start_addr;
   logic [ADDR_W-1:0]   wb_calc;
   logic                accept;
   logic                hs;
   logic                unused_code;

   assign unused_code = ^code;
   assign list_in     = code[NUM_REGS-1:0];
   assign accept      = in_valid & in_ready;
   assign hs          = uop_valid & uop_ready;
   assign rem_after   = rem & (rem - 1'b1);

   function automatic logic [RID_W-1:0] lowest_bit(input logic [NUM_REGS-1:0] v);
      lowest_bit = '0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (v[i]) lowest_bit = RID_W'(i);
      end
   endfunction

   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         count = count + {{(ADDR_W-1){1'b0}}, list_in[i]};
      end
      span = count * ADDR_W'(STRIDE);
      case ({code[24], code[23]})
         2'b01:   start_addr = base;
         2'b11:   start_addr = base + ADDR_W'(STRIDE);
         2'b00:   start_addr = base - span + ADDR_W'(STRIDE);
         default: start_addr = base - span;
      endcase
      wb_calc = code[23] ? (base + span) : (base - span);
   end

   // The next register to present: from the new list on accept, otherwise the list after this handshake.
   always_comb begin
      sel        = (state == IDLE) ? list_in : rem_after;
      sel_reg    = lowest_bit(sel);
      sel_single = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         rem        <= '0;
         wb_q       <= 1'b0;
         wb_target  <= '0;
         uop_valid  <= 1'b0;
         uop_addr   <= '0;
         uop_reg    <= '0;
         uop_load   <= 1'b0;
         uop_last   <= 1'b0;
         wb_en      <= 1'b0;
         wb_value   <= '0;
         empty_list <= 1'b0;
      end else begin
         wb_en      <= 1'b0;
         empty_list <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (list_in == '0) begin
                     empty_list <= 1'b1;
                  end else begin
                     state     <= ISSUE;
                     in_ready  <= 1'b0;
                     rem       <= list_in;
                     wb_q      <= code[21];
                     wb_target <= wb_calc;
                     uop_valid <= 1'b1;
                     uop_addr  <= start_addr;
                     uop_reg   <= sel_reg;
                     uop_last  <= sel_single;
                     uop_load  <= code[20];
                  end
               end
            end
            ISSUE: begin
               if (hs) begin
                  if (uop_last) begin
                     state     <= IDLE;
                     in_ready  <= 1'b1;
                     uop_valid <= 1'b0;
                     uop_last  <= 1'b0;
                     wb_en     <= wb_q;
                     if (wb_q) wb_value <= wb_target;
                  end else begin
                     rem      <= rem_after;
                     uop_addr <= uop_addr + ADDR_W'(STRIDE);
                     uop_reg  <= sel_reg;
                     uop_last <= sel_single;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DECODER_LDM_PC_BRANCH_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uop_pc_load <= 1'b0;
      end else if (state == IDLE) begin
         if (accept && list_in != '0) begin
            uop_pc_load <= code[20] && (sel_reg == RID_W'(NUM_REGS - 1));
         end
      end else if (hs) begin
         uop_pc_load <= !uop_last && uop_load && (sel_reg == RID_W'(NUM_REGS - 1));
      end
   end
`else
   assign uop_pc_load = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_arm_ldm_seq.sv
// Scoreboard bench for decoder_arm_ldm_seq: expected micro-ops and writebacks queued at drive time.
module tb_decoder_arm_ldm_seq;

   localparam int W = 39;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] code = '0;
   logic [31:0] base = '0;
   logic        uop_valid;
   logic        uop_ready = 1'b0;
   logic [31:0] uop_addr;
   logic [3:0]  uop_reg;
   logic        uop_load;
   logic        uop_last;
   logic        uop_pc_load;
   logic        wb_en;
   logic [31:0] wb_value;
   logic        empty_list;

   logic [W-1:0]  exp_q[$];
   logic [31:0]   wb_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   bit            rand_ready = 1'b0;
   logic [W-1:0]  held;
   bit            prev_stall = 1'b0;

   decoder_arm_ldm_seq dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .code(code), .base(base), .uop_valid(uop_valid), .uop_ready(uop_ready),
      .uop_addr(uop_addr), .uop_reg(uop_reg), .uop_load(uop_load),
      .uop_last(uop_last), .uop_pc_load(uop_pc_load), .wb_en(wb_en),
      .wb_value(wb_value), .empty_list(empty_list)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] make_code(input bit p, input bit u, input bit w,
                                             input bit l, input logic [15:0] list);
      logic [31:0] c;
      c = 32'he800_0000;
      c[24] = p; c[23] = u; c[21] = w; c[20] = l;
      c[15:0] = list;
      return c;
   endfunction

   // Reference model: address order and values straight from the LDM/STM addressing modes.
   task automatic push_expect(input logic [31:0] b, input logic [31:0] c);
      logic [15:0] list;
      logic [31:0] span, addr;
      int          n, k;
      bit          pc;
      list = c[15:0];
      n = $countones(list);
      span = 32'(n) * 32'd4;
      if (c[24] && c[23])       addr = b + 32'd4;
      else if (c[23])           addr = b;
      else if (c[24])           addr = b - span;
      else                      addr = b - span + 32'd4;
      k = 0;
      for (int i = 0; i < 16; i++) begin
         if (list[i]) begin
            k++;
`ifdef DECODER_LDM_PC_BRANCH_EN
            pc = c[20] && (i == 15);
`else
            pc = 1'b0;
`endif
            exp_q.push_back({pc, (k == n), c[20], 4'(i), addr});
            addr = addr + 32'd4;
         end
      end
      if (n != 0 && c[21]) wb_q.push_back(c[23] ? b + span : b - span);
   endtask

   task automatic send(input logic [31:0] b, input logic [31:0] c);
      bit ok;
      push_expect(b, c);
      @(posedge clk); #1;
      in_valid = 1'b1; code = c; base = b;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) check("accept_timeout", 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !uop_valid) begin ok = 1'b1; break; end
      end
      if (!ok) check("done_timeout", 1, 0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) uop_ready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compare every handshake, writeback and hold behaviour against the queues.
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall && uop_valid)
               check("hold", {uop_pc_load, uop_last, uop_load, uop_reg, uop_addr}, held);
            if (uop_valid) check("busy_in_ready", in_ready, 0);
            if (uop_valid && uop_ready) begin
               if (exp_q.size() == 0) check("uop_unexpected", 1, 0);
               else check("uop", {uop_pc_load, uop_last, uop_load, uop_reg, uop_addr},
                          exp_q.pop_front());
            end
            if (wb_en) begin
               if (wb_q.size() == 0) check("wb_unexpected", wb_value, 0);
               else check("wb_value", wb_value, wb_q.pop_front());
            end
            prev_stall = uop_valid && !uop_ready;
            held = {uop_pc_load, uop_last, uop_load, uop_reg, uop_addr};
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", in_ready, 1);
      check("rst_uop_valid", uop_valid, 0);
      check("rst_uop_addr", uop_addr, 0);
      check("rst_wb_en", wb_en, 0);
      check("rst_wb_value", wb_value, 0);
      check("rst_empty", empty_list, 0);
      rst = 1'b0;
      uop_ready = 1'b1;

      send(32'h1000, make_code(0, 1, 1, 1, 16'h000B));   // LDMIA
      wait_done();
      send(32'h2000, make_code(1, 0, 1, 0, 16'h4010));   // STMDB
      wait_done();
      send(32'h0100, make_code(1, 1, 0, 1, 16'h0003));   // LDMIB
      wait_done();
      send(32'h0100, make_code(0, 0, 0, 1, 16'h0003));   // LDMDA
      wait_done();
      send(32'hFFFF_FFFC, make_code(0, 1, 1, 1, 16'h0003)); // address wrap
      wait_done();
      send(32'h0040, make_code(0, 1, 0, 1, 16'h8001));   // PC in list
      wait_done();
      send(32'h0040, make_code(0, 1, 0, 0, 16'h8000));   // PC stored, never a branch
      wait_done();

      // Backpressure mid-sequence, with a stray in_valid that must be ignored.
      send(32'h3000, make_code(0, 1, 1, 1, 16'h00F0));
      @(posedge clk); #1;
      uop_ready = 1'b0;
      in_valid = 1'b1; code = make_code(0, 1, 1, 1, 16'hFFFF); base = 32'h9999_0000;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b0;
      uop_ready = 1'b1;
      wait_done();

      // Empty register list.
      send(32'h5000, make_code(0, 1, 1, 1, 16'h0000));
      @(negedge clk);
      check("empty_pulse", empty_list, 1);
      check("empty_no_uop", uop_valid, 0);
      check("empty_in_ready", in_ready, 1);
      @(negedge clk);
      check("empty_one_cycle", empty_list, 0);
      check("empty_no_wb", wb_en, 0);

      // Asynchronous reset during the second of four micro-ops.
      send(32'h6000, make_code(0, 1, 1, 1, 16'h000F));
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("arst_uop_valid", uop_valid, 0);
      check("arst_uop_addr", uop_addr, 0);
      check("arst_uop_reg", uop_reg, 0);
      check("arst_uop_last", uop_last, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_wb_value", wb_value, 0);
      exp_q.delete();
      wb_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge clk);

      // Random instructions under random backpressure.
      rand_ready = 1'b1;
      for (int t = 0; t < 12; t++) begin
         send($urandom(), make_code(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                    16'($urandom_range(0, 65535))));
         wait_done();
      end
      rand_ready = 1'b0;
      uop_ready = 1'b1;

      check("uop_queue_empty", exp_q.size(), 0);
      check("wb_queue_empty", wb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
